// File: rtl/key_event_pkg.sv
// Shared constants for the key event generator: FSM state encoding and event codes.
package key_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELWAIT = 2'd3
  } state_t;

  localparam logic [1:0] EVT_SHORT  = 2'd0;
  localparam logic [1:0] EVT_LONG   = 2'd1;
  localparam logic [1:0] EVT_REPEAT = 2'd2;

endpackage

// File: rtl/key_prio_enc.sv
// Lowest-index priority encoder over the debounced key lines.
module key_prio_enc #(
  parameter int WIDTH = 4,
  parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] bits,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any = |bits;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      idx = bits[i] ? IW'(i) : idx;
    end
  end

endmodule

// File: rtl/key_event.sv
// Key press classifier: SHORT / LONG (and REPEAT when KEY_EVENT_REPEAT_EN is defined)
// events for one tracked key, delivered through a valid/ready slot with sticky overflow.
module key_event
  import key_event_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int LONG_TIME   = 50_000_000,
  parameter int REPEAT_TIME = 10_000_000,
  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CW = (LONG_TIME > 1) ? $clog2(LONG_TIME) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key_lvl,
  output logic             evt_vld,
  input  logic             evt_rdy,
  output logic [KW-1:0]    evt_key,
  output logic [1:0]       evt_type,
  output logic             evt_ovf
);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TIME - 1);

  if (REPEAT_TIME > LONG_TIME) begin : g_bad_repeat
    $error("key_event: REPEAT_TIME must not exceed LONG_TIME");
  end

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [KW-1:0] key_idx, key_idx_nx;
  logic [KW-1:0] enc_idx;
  logic          enc_any;
  logic          held;
  logic          emit;
  logic [1:0]    emit_type;

  key_prio_enc #(.WIDTH(WIDTH), .IW(KW)) u_enc (
    .bits (key_lvl),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  assign held = key_lvl[key_idx];

  // State, counter and tracked-key registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      key_idx <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      key_idx <= key_idx_nx;
    end
  end

  // Next-state and counter logic; release is tested before the threshold so it wins a tie.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    key_idx_nx = key_idx;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (enc_any) begin
          key_idx_nx = enc_idx;
          state_nx   = ST_PRESS;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (!held) begin
          state_nx = ST_RELWAIT;
          cnt_nx   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nx = ST_HOLD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ST_HOLD: begin
`ifdef KEY_EVENT_REPEAT_EN
        if (!held) begin
          state_nx = ST_RELWAIT;
          cnt_nx   = '0;
        end else if (cnt == CW'(REPEAT_TIME - 1)) begin
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
`else
        cnt_nx = '0;
        if (!held) begin
          state_nx = ST_RELWAIT;
        end else begin
          state_nx = ST_HOLD;
        end
`endif
      end
      ST_RELWAIT: begin
        cnt_nx = '0;
        if (key_lvl == '0) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_RELWAIT;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Event emission decoded from the current state and inputs.
  always_comb begin
    emit      = 1'b0;
    emit_type = EVT_SHORT;
    case (state)
      ST_PRESS: begin
        if (!held) begin
          emit      = 1'b1;
          emit_type = EVT_SHORT;
        end else if (cnt == LONG_LAST) begin
          emit      = 1'b1;
          emit_type = EVT_LONG;
        end else begin
          emit = 1'b0;
        end
      end
`ifdef KEY_EVENT_REPEAT_EN
      ST_HOLD: begin
        if (held && (cnt == CW'(REPEAT_TIME - 1))) begin
          emit      = 1'b1;
          emit_type = EVT_REPEAT;
        end else begin
          emit = 1'b0;
        end
      end
`endif
      default: begin
        emit      = 1'b0;
        emit_type = EVT_SHORT;
      end
    endcase
  end

  // Single-entry event slot: a new event replaces one being accepted, else it overflows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_vld  <= 1'b0;
      evt_key  <= '0;
      evt_type <= 2'd0;
      evt_ovf  <= 1'b0;
    end else if (emit) begin
      if (!evt_vld || evt_rdy) begin
        evt_vld  <= 1'b1;
        evt_key  <= key_idx;
        evt_type <= emit_type;
      end else begin
        evt_ovf <= 1'b1;
      end
    end else if (evt_rdy) begin
      evt_vld <= 1'b0;
    end else begin
      evt_vld <= evt_vld;
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event (WIDTH=4, LONG_TIME=20, REPEAT_TIME=5); follows
// KEY_EVENT_REPEAT_EN the same way the DUT does.
module tb_key_event;
  import key_event_pkg::*;

  localparam int LT = 20;
  localparam int RT = 5;
`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_lvl;
  logic       evt_rdy;
  logic       evt_vld;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic       evt_ovf;

  int checks   = 0;
  int failures = 0;
  int dut_acc  = 0;

  // Reference model: press age in cycles since capture, plus a one-entry output slot.
  int         m_age;
  bit         m_wait;
  int         m_key;
  bit         m_vld;
  logic [1:0] m_ekey;
  logic [1:0] m_etype;
  bit         m_ovf;

  key_event #(.WIDTH(4), .LONG_TIME(LT), .REPEAT_TIME(RT)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_lvl  (key_lvl),
    .evt_vld  (evt_vld),
    .evt_rdy  (evt_rdy),
    .evt_key  (evt_key),
    .evt_type (evt_type),
    .evt_ovf  (evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_age = -1; m_wait = 1'b0; m_key = 0;
    m_vld = 1'b0; m_ekey = 2'd0; m_etype = 2'd0; m_ovf = 1'b0;
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_edge(input logic [3:0] kl, input bit rdy);
    bit emit;
    logic [1:0] ty;
    emit = 1'b0;
    ty   = EVT_SHORT;
    if (m_wait) begin
      if (kl == 4'd0) m_wait = 1'b0;
    end else if (m_age < 0) begin
      if (kl != 4'd0) begin
        m_key = lowest(kl);
        m_age = 0;
      end
    end else begin
      m_age++;
      if (!kl[m_key]) begin
        if (m_age <= LT) begin emit = 1'b1; ty = EVT_SHORT; end
        m_age  = -1;
        m_wait = 1'b1;
      end else if (m_age == LT) begin
        emit = 1'b1; ty = EVT_LONG;
      end else if (REP_EN && m_age > LT && ((m_age - LT) % RT) == 0) begin
        emit = 1'b1; ty = EVT_REPEAT;
      end
    end
    if (emit) begin
      if (!m_vld || rdy) begin
        m_vld = 1'b1; m_ekey = 2'(m_key); m_etype = ty;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (rdy) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".vld"}, 32'(evt_vld), 32'(m_vld));
    chk({tag, ".key"}, 32'(evt_key), 32'(m_ekey));
    chk({tag, ".type"}, 32'(evt_type), 32'(m_etype));
    chk({tag, ".ovf"}, 32'(evt_ovf), 32'(m_ovf));
  endtask

  task automatic step(input logic [3:0] kl, input bit rdy, input string tag);
    key_lvl = kl;
    evt_rdy = rdy;
    if (evt_vld && evt_rdy) dut_acc++;
    model_edge(kl, rdy);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(posedge clk);
    #1;
    compare_all({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    int base;
    rst     = 1'b1;
    key_lvl = 4'd0;
    evt_rdy = 1'b1;
    #2;
    model_reset();
    compare_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) step(4'd0, 1'b1, "idle");

    // Short press on key 2
    base = dut_acc;
    repeat (10) step(4'b0100, 1'b1, "short");
    repeat (4) step(4'b0000, 1'b1, "short_rel");
    chk("short_count", 32'(dut_acc - base), 32'd1);

    // Long press on key 0: capture + 40 held cycles
    base = dut_acc;
    repeat (41) step(4'b0001, 1'b1, "long");
    repeat (4) step(4'b0000, 1'b1, "long_rel");
    chk("long_count", 32'(dut_acc - base), REP_EN ? 32'd5 : 32'd1);

    // Multi-key: key 1 tracked, key 3 still held after release
    repeat (5) step(4'b1010, 1'b1, "multi");
    step(4'b1000, 1'b1, "multi_rel");
    chk("multi_key", 32'(evt_key), 32'd1);
    chk("multi_type", 32'(evt_type), 32'(EVT_SHORT));
    repeat (30) step(4'b1000, 1'b1, "multi_wait");
    chk("multi_nocap", 32'(evt_vld), 32'd0);
    repeat (3) step(4'b0000, 1'b1, "multi_idle");

    // Backpressure: two short presses with evt_rdy low
    repeat (3) step(4'b0010, 1'b0, "bp1");
    repeat (3) step(4'b0000, 1'b0, "bp1_rel");
    repeat (3) step(4'b0100, 1'b0, "bp2");
    repeat (3) step(4'b0000, 1'b0, "bp2_rel");
    chk("bp_key_kept", 32'(evt_key), 32'd1);
    chk("bp_ovf", 32'(evt_ovf), 32'd1);
    repeat (3) step(4'b0000, 1'b1, "bp_drain");
    chk("bp_ovf_sticky", 32'(evt_ovf), 32'd1);

    // Reset mid-press, key still held afterwards
    repeat (10) step(4'b0001, 1'b1, "midrst_press");
    apply_reset("midrst");
    base = dut_acc;
    repeat (21) step(4'b0001, 1'b1, "midrst_again");
    chk("midrst_long", 32'(evt_type), 32'(EVT_LONG));
    repeat (4) step(4'b0000, 1'b1, "midrst_rel");
    chk("midrst_count", 32'(dut_acc - base), 32'd1);

    // Boundary: release exactly when the counter reaches its threshold
    repeat (20) step(4'b0001, 1'b1, "bound");
    step(4'b0000, 1'b1, "bound_rel");
    chk("bound_vld", 32'(evt_vld), 32'd1);
    chk("bound_type", 32'(evt_type), 32'(EVT_SHORT));
    repeat (3) step(4'b0000, 1'b1, "bound_idle");
    repeat (21) step(4'b0001, 1'b1, "bound_long");
    chk("bound_long_type", 32'(evt_type), 32'(EVT_LONG));
    repeat (3) step(4'b0000, 1'b1, "bound_long_rel");

    // Randomized segments against the model
    for (int s = 0; s < 40; s++) begin
      logic [3:0] pat;
      int len;
      pat = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 32);
      if (s == 25) apply_reset("rand_rst");
      for (int c = 0; c < len; c++) step(pat, $urandom_range(0, 3) != 0, "rand");
    end
    repeat (3) step(4'b0000, 1'b1, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter WIDTH, default 4, is the number of debounced key lines.
REQ-002 Parameter LONG_TIME, default 50_000_000, is the long-press threshold in clk cycles (1 s at 50 MHz).
REQ-003 Parameter REPEAT_TIME, default 10_000_000, is the auto-repeat period in clk cycles; it SHALL be no greater than LONG_TIME.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 key_lvl  input  WIDTH  debounced key levels from the debounce stage; 1 means pressed, and the signal is already synchronous to clk.
REQ-007 evt_vld  output  1  an event is pending.
REQ-008 evt_rdy  input  1  the consumer accepts the event.
REQ-009 evt_key  output  clog2(WIDTH)  index of the key that produced the event.
REQ-010 evt_type  output  2  event code: 0 SHORT, 1 LONG, 2 REPEAT; code 3 is unused.
REQ-011 evt_ovf  output  1  sticky flag: an event was dropped.

Function
REQ-012 The FSM SHALL have four states (IDLE, PRESS, HOLD, RELWAIT) and a single tracked key, key_idx.
REQ-013 IDLE: when key_lvl != 0, the FSM SHALL capture the lowest-index set bit into key_idx, clear cnt and go to PRESS on that edge.
REQ-014 PRESS: cnt SHALL increment every cycle; key_lvl bits other than key_idx SHALL be ignored.
REQ-015 PRESS: if key_lvl[key_idx]==0 before cnt reaches LONG_TIME-1, the FSM SHALL emit SHORT and go to RELWAIT.
REQ-016 PRESS: when cnt==LONG_TIME-1 and key_lvl[key_idx]==1, the FSM SHALL emit LONG, clear cnt and go to HOLD.
REQ-017 If release and cnt==LONG_TIME-1 occur in the same cycle, the release SHALL win and SHORT SHALL be emitted.
REQ-018 HOLD: when key_lvl[key_idx]==0, the FSM SHALL go to RELWAIT and SHALL NOT emit an event.
REQ-019 RELWAIT: the FSM SHALL go to IDLE only once key_lvl == 0; this guarantees no new capture while any key is still held.
REQ-020 Event latency: evt_vld, evt_key and evt_type SHALL be registered on the same clock edge as the emitting state transition.
REQ-021 Handshake: the event SHALL be held stable while evt_vld=1 and evt_rdy=0.
REQ-022 Handshake: evt_vld SHALL clear on the edge where evt_vld=1 and evt_rdy=1, unless a new event is loaded on that same edge.
REQ-023 Emit while evt_vld=1 and evt_rdy=0: the new event SHALL be dropped, the pending event SHALL be kept, and evt_ovf SHALL set and remain set until rst.
REQ-024 Emit in the same cycle as acceptance (evt_vld=1, evt_rdy=1): the new event SHALL be loaded, evt_vld SHALL stay 1, and evt_ovf SHALL be unchanged.
REQ-025 Counter width SHALL be clog2(LONG_TIME).
REQ-026 cnt SHALL be held at 0 in IDLE and RELWAIT, and SHALL never wrap past its terminal value.

Reset
REQ-027 On rst: state SHALL be IDLE, and cnt, key_idx, evt_vld, evt_key, evt_type and evt_ovf SHALL all be 0.
REQ-028 Reset asserted mid-press SHALL abort tracking without emitting an event.
REQ-029 After rst deasserts with a key still held, the FSM SHALL capture that key as a fresh press.

Configuration
REQ-030 With macro KEY_EVENT_REPEAT_EN defined, the HOLD state SHALL count cnt to REPEAT_TIME-1, emit REPEAT for key_idx, clear cnt and repeat the cycle while the key stays held.
REQ-031 With KEY_EVENT_REPEAT_EN undefined, HOLD SHALL emit nothing, evt_type 2 SHALL never occur, and the repeat logic SHALL be absent from the build.

Structure
REQ-032 Shared package key_event_pkg SHALL hold the state encoding constants and the event code constants (SHORT, LONG, REPEAT).
REQ-033 Sub-module key_prio_enc SHALL be a combinational lowest-index priority encoder: WIDTH-bit input, clog2(WIDTH) index output, plus an any-bit-set output.

Verification
Benches use WIDTH=4, LONG_TIME=20, REPEAT_TIME=5 and evt_rdy held at 1 unless stated.
REQ-034 Short press: key_lvl=4'b0100 for 10 cycles, then 0 -> exactly one event with evt_key=2 and evt_type=SHORT, evt_ovf=0.
REQ-035 Long press: key_lvl=4'b0001 for 40 cycles -> LONG with evt_key=0 at cycle 20 after capture, and no event on release; with KEY_EVENT_REPEAT_EN also REPEAT at cycles 25, 30, 35 and 40.
REQ-036 Multi-key: key_lvl=4'b1010 -> key 1 tracked; releasing bit 1 with bit 3 held -> SHORT for key 1, FSM stays in RELWAIT with no capture until key_lvl=0.
REQ-037 Backpressure: evt_rdy=0, two short presses -> first event held stable, second dropped, evt_ovf=1 and stays 1 after evt_rdy returns to 1.
REQ-038 Reset mid-press: rst pulsed at cycle 10 of a press -> all outputs 0, no event; key still held after rst releases -> new capture and LONG 20 cycles later.
REQ-039 Boundary: release in the exact cycle cnt==19 -> SHORT, not LONG.
